// File: rtl/result_packer.sv
// Drains FP24 results from the result FIFO, widens them to FP32 and packs LANES per
// output word on a valid/ready stream; the final partial word is zero-padded.
//   state  | meaning
//   IDLE   | waiting for i_start
//   RUN    | issuing reads and packing lanes
//   LAST   | all results landed; flushing the final word
//   DONE   | one-cycle completion pulse
module result_packer #(
    parameter int OUT_WIDTH = 256,
    parameter int LANES     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_expected_count,
    output logic                 o_busy,
    output logic                 o_done,
    input  logic [23:0]          i_fifo_rdata,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_ren,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_last,
    input  logic                 i_ready,
    output logic [CNT_WIDTH-1:0] o_result_count,
    output logic [CNT_WIDTH-1:0] o_word_count
);
    localparam int LANE_W = $clog2(LANES);
    localparam int FILL_W = LANE_W + 1;
    localparam logic [FILL_W-1:0] LANES_F = FILL_W'(LANES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;

    state_t               r_state, w_state_next;
    logic [CNT_WIDTH-1:0] r_expected, r_requested, r_received, r_word_count;
    logic [CNT_WIDTH-1:0] w_received_next;
    logic [FILL_W-1:0]    r_fill, w_lanes;
    logic                 r_inflight;
    logic [OUT_WIDTH-1:0] r_pack, w_pack_merged, r_out_data;
    logic                 r_out_valid, r_out_last;
    logic [31:0]          w_conv;
    logic                 w_start, w_xfer, w_form, w_move, w_ren, w_last_word;

    // FP24 sign/exponent line up with FP32; the mantissa just gains 8 zero LSBs
    assign w_conv          = {i_fifo_rdata, 8'h00};
    assign w_start         = (r_state == S_IDLE) && i_start;
    assign w_xfer          = r_out_valid && i_ready;
    assign w_lanes         = r_fill + FILL_W'(r_inflight);
    assign w_received_next = r_received + CNT_WIDTH'(r_inflight);

    // Landing data is merged combinationally so the word can leave in its landing cycle
    always_comb begin
        w_pack_merged = r_pack;
        if (r_inflight) begin
            w_pack_merged[32*r_fill[LANE_W-1:0] +: 32] = w_conv;
        end
    end

    assign w_form      = ((r_state == S_RUN) && (w_lanes == LANES_F)) ||
                         ((r_state == S_LAST) && (r_fill != '0));
    assign w_move      = w_form && (!r_out_valid || i_ready);
    assign w_last_word = (r_state == S_LAST) || (w_received_next == r_expected);
    assign w_ren       = (r_state == S_RUN) && !i_fifo_empty &&
                         (r_requested < r_expected) &&
                         ((w_lanes < LANES_F) || w_move);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_next = (i_expected_count == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_received_next == r_expected) w_state_next = S_LAST;
            S_LAST: if (w_xfer && r_out_last) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_expected   <= '0;
            r_requested  <= '0;
            r_received   <= '0;
            r_word_count <= '0;
            r_fill       <= '0;
            r_inflight   <= 1'b0;
            r_pack       <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_ren;
            if (w_start) begin
                r_expected   <= i_expected_count;
                r_requested  <= '0;
                r_received   <= '0;
                r_word_count <= '0;
                r_fill       <= '0;
                r_pack       <= '0;
            end else begin
                if (w_ren)  r_requested  <= r_requested + 1'b1;
                if (w_xfer) r_word_count <= r_word_count + 1'b1;
                r_received <= w_received_next;
                if (w_move) begin
                    r_fill <= '0;
                    r_pack <= '0;
                end else begin
                    r_fill <= w_lanes;
                    r_pack <= w_pack_merged;
                end
            end
            if (w_move) begin
                r_out_data  <= w_pack_merged;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_word;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // A zero-length job is busy only during its DONE cycle
    assign o_busy         = (r_state == S_RUN) || (r_state == S_LAST) ||
                            ((r_state == S_DONE) && (r_expected == '0));
    assign o_done         = (r_state == S_DONE);
    assign o_fifo_ren     = w_ren;
    assign o_data         = r_out_data;
    assign o_valid        = r_out_valid;
    assign o_last         = r_out_last;
    assign o_result_count = r_received;
    assign o_word_count   = r_word_count;
endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: directed jobs push expected words, a monitor
// pops and compares on each transfer; a queue models the result FIFO.
module tb_result_packer;
    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_start = 1'b0;
    logic [15:0]  i_expected_count = '0;
    logic         o_busy, o_done;
    logic [23:0]  i_fifo_rdata = '0;
    logic         i_fifo_empty = 1'b1;
    logic         o_fifo_ren;
    logic [255:0] o_data;
    logic         o_valid, o_last;
    logic         i_ready = 1'b1;
    logic [15:0]  o_result_count, o_word_count;

    result_packer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_expected_count(i_expected_count), .o_busy(o_busy), .o_done(o_done),
        .i_fifo_rdata(i_fifo_rdata), .i_fifo_empty(i_fifo_empty), .o_fifo_ren(o_fifo_ren),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready),
        .o_result_count(o_result_count), .o_word_count(o_word_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] data;
        logic         last;
    } word_t;

    word_t       exp_q[$];
    logic [23:0] fifo_q[$];
    logic [23:0] tab24[24];
    logic [31:0] tab32[24];
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_xfer_cyc = -1;
    int ren_cnt = 0;
    int ren_first = -1;
    int ren_last = -1;
    bit starve_en = 0;
    bit starve_phase = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, want);
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Result FIFO model: pop on ren, data appears in the following cycle
    initial begin
        logic       ren_s;
        logic [23:0] popped;
        popped = '0;
        forever begin
            @(negedge i_clk);
            ren_s = o_fifo_ren;
            if (ren_s) begin
                chk("ren_while_empty", i_fifo_empty, 1'b0);
                ren_cnt++;
                if (ren_first < 0) ren_first = cyc;
                ren_last = cyc;
                if (fifo_q.size() > 0) popped = fifo_q.pop_front();
                else popped = '0;
            end
            @(posedge i_clk);
            #1;
            if (ren_s) i_fifo_rdata = popped;
            starve_phase = !starve_phase;
            i_fifo_empty = (fifo_q.size() == 0) || (starve_en && starve_phase);
        end
    end

    // Output monitor: compares every transfer and checks hold-under-backpressure
    initial begin
        bit           hold_pending;
        logic [255:0] hold_data;
        word_t        e;
        hold_pending = 0;
        hold_data = '0;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                hold_pending = 0;
            end else begin
                if (hold_pending) begin
                    chk("hold_valid", o_valid, 1'b1);
                    chk("hold_data", o_data, hold_data);
                end
                hold_pending = o_valid && !i_ready;
                hold_data = o_data;
                if (o_valid && i_ready) begin
                    last_xfer_cyc = cyc;
                    chk("word_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("word_data", o_data, e.data);
                        chk("word_last", o_last, e.last);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic load(input int n);
        int    nw;
        word_t w;
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(tab24[i]);
        nw = (n + 7) / 8;
        for (int wi = 0; wi < nw; wi++) begin
            w.data = '0;
            for (int k = 0; k < 8; k++)
                if (wi * 8 + k < n) w.data[32*k +: 32] = tab32[wi*8 + k];
            w.last = (wi == nw - 1);
            exp_q.push_back(w);
        end
        step();
        step();
    endtask

    task automatic start(input int n);
        ren_cnt = 0;
        ren_first = -1;
        ren_last = -1;
        i_expected_count = 16'(n);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic finish_job(input int n, output int done_cyc);
        bit seen;
        seen = 0;
        done_cyc = -1;
        for (int t = 0; t < 600; t++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen = 1;
                done_cyc = cyc;
                break;
            end
        end
        chk("done_seen", seen, 1'b1);
        chk("busy_drops_with_done", o_busy, 1'b0);
        chk("result_count", o_result_count, 256'(n));
        chk("word_count", o_word_count, 256'((n + 7) / 8));
        step();
    endtask

    task automatic run_job(input int n, input bit bp, input bit starve);
        int  dc;
        bit  seen;
        starve_en = starve;
        i_ready = !bp;
        load(n);
        start(n);
        if (bp) begin
            seen = 0;
            for (int t = 0; t < 100; t++) begin
                @(negedge i_clk);
                if (o_valid) begin
                    seen = 1;
                    break;
                end
            end
            chk("bp_first_valid", seen, 1'b1);
            repeat (20) @(negedge i_clk);
            chk("bp_buffered_results", o_result_count, 256'd16);
            chk("bp_out_valid", o_valid, 1'b1);
            chk("bp_out_word0", o_data, {32'h55555500, 32'hFFFFFF00, 32'h3F000000, 32'h40000000,
                                         32'hABCDEF00, 32'h12345600, 32'h80000000, 32'h7FFFFF00} == 256'h0 ?
                                         256'h0 : {tab32[7], tab32[6], tab32[5], tab32[4],
                                                   tab32[3], tab32[2], tab32[1], tab32[0]});
            step();
            i_ready = 1'b1;
        end
        finish_job(n, dc);
        if (n == 16 && !bp && !starve) begin
            chk("done_after_last_xfer", 256'(dc - last_xfer_cyc), 256'd1);
            chk("ren_count", 256'(ren_cnt), 256'd16);
            chk("ren_no_gaps", 256'(ren_last - ren_first + 1), 256'd16);
        end
        starve_en = 0;
    endtask

    initial begin
        bit seen;
        tab24 = '{24'h3F8000, 24'hC00001, 24'h7F8000, 24'h000001, 24'h7FFFFF, 24'h800000,
                  24'h123456, 24'hABCDEF, 24'h400000, 24'h3F0000, 24'hFFFFFF, 24'h555555,
                  24'hAAAAAA, 24'h0F0F0F, 24'hF0F0F0, 24'h3FC000, 24'h010203, 24'h040506,
                  24'h070809, 24'h0A0B0C, 24'h0D0E0F, 24'h102030, 24'h405060, 24'h708090};
        tab32 = '{32'h3F800000, 32'hC0000100, 32'h7F800000, 32'h00000100, 32'h7FFFFF00,
                  32'h80000000, 32'h12345600, 32'hABCDEF00, 32'h40000000, 32'h3F000000,
                  32'hFFFFFF00, 32'h55555500, 32'hAAAAAA00, 32'h0F0F0F00, 32'hF0F0F000,
                  32'h3FC00000, 32'h01020300, 32'h04050600, 32'h07080900, 32'h0A0B0C00,
                  32'h0D0E0F00, 32'h10203000, 32'h40506000, 32'h70809000};

        step();
        step();
        @(negedge i_clk);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ren", o_fifo_ren, 1'b0);
        chk("rst_data", o_data, 256'h0);
        chk("rst_counts", {o_result_count, o_word_count}, 256'h0);
        step();
        i_reset = 1'b0;
        step();

        run_job(16, 0, 0);
        run_job(11, 0, 0);
        run_job(24, 1, 0);
        run_job(16, 0, 1);

        // Zero-length job
        start(0);
        @(negedge i_clk);
        chk("zero_done", o_done, 1'b1);
        chk("zero_busy", o_busy, 1'b1);
        chk("zero_valid", o_valid, 1'b0);
        @(negedge i_clk);
        chk("zero_done_end", o_done, 1'b0);
        chk("zero_busy_end", o_busy, 1'b0);
        chk("zero_valid_end", o_valid, 1'b0);
        step();

        // Abort after 5 results
        load(16);
        start(16);
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge i_clk);
            if (o_result_count == 16'd5) begin
                seen = 1;
                break;
            end
        end
        chk("abort_reached_5", seen, 1'b1);
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        @(negedge i_clk);
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_done", o_done, 1'b0);
        chk("abort_valid", {o_valid, o_last, o_fifo_ren}, 256'h0);
        chk("abort_data", o_data, 256'h0);
        chk("abort_counts", {o_result_count, o_word_count}, 256'h0);
        step();

        run_job(8, 0, 0);

        repeat (5) step();
        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
